jtag_tap_fsm: RTL and testbench
===============================

# jtag_tap_fsm

TAP controller for the JTAG block. It implements the 16-state IEEE 1149.1 state machine driven by TMS, and decodes the Capture/Shift/Update strobes that feed the shared shift register. It also holds the current instruction, which is latched from that shift register in Update-IR. It sits directly upstream of the shift register and supplies its `i_stateIsCapture*` and `i_stateIsShift*` inputs.

## Interface
- No module parameters. `REG_W`, state enum and instruction codes come from `jtag_pa`.
- `i_tclk` in 1: TCK. Sole clock; all state updates on posedge.
- `i_trst_n` in 1: reset. Synchronous, active-high: a 1 sampled on posedge `i_tclk` resets the block.
- `i_tms` in 1: test mode select, sampled on posedge.
- `i_shiftReg` in REG_W: shift-register contents, latched as the instruction in Update-IR.
- `o_state` out 4: current TAP state (`tap_state_t`).
- `o_stateIsTestLogicReset` out 1: the state is Test-Logic-Reset.
- `o_stateIsCaptureDr` and `o_stateIsCaptureIr` out 1 each.
- `o_stateIsShiftDr` and `o_stateIsShiftIr` out 1 each.
- `o_stateIsUpdateDr` and `o_stateIsUpdateIr` out 1 each.
- `o_instruction` out REG_W: active instruction.

## Operation
- State register `state_q`. Next state is a pure function of `state_q` and `i_tms`. Transitions are listed as TMS=0 / TMS=1:
  - TLR: RTI / TLR
  - RTI: RTI / SelDR
  - SelDR: CapDR / SelIR
  - SelIR: CapIR / TLR
  - CapDR: ShDR / Ex1DR
  - ShDR: ShDR / Ex1DR
  - Ex1DR: PauseDR / UpdDR
  - PauseDR: PauseDR / Ex2DR
  - Ex2DR: ShDR / UpdDR
  - UpdDR: RTI / SelDR
  - The IR column mirrors the DR column.
- All `o_stateIs*` flags are combinational decodes of `state_q`. They are mutually exclusive, and at most one is high.
- Instruction register `instr_q`:
  - In the cycle after a posedge taken in UpdIR, `instr_q` equals `i_shiftReg`.
  - While `state_q` is TLR, `instr_q` is loaded with `IR_RESET_CODE` on every posedge.
  - Otherwise `instr_q` holds.
- `o_instruction` = `instr_q`. `o_state` = `state_q`.
- Reset (`i_trst_n`=1) overrides TMS:
  - `state_q` becomes TLR and `instr_q` becomes `IR_RESET_CODE`.
  - Applies from any state, including mid-Shift.
- Five consecutive TMS=1 edges reach TLR from any state without reset. The FSM has no illegal states: all 16 encodings are valid.

## Timing
- Reset values, after the reset edge:
  - `o_state`=TLR (4'hF), `o_stateIsTestLogicReset`=1, all other flags 0.
  - `o_instruction`=`IR_RESET_CODE`.
- Latency:
  - TMS sampled at edge n determines `o_state` after edge n, so flags change one TCK after the deciding TMS.
  - Capture/Shift flags are valid for the whole cycle in which the shift register samples them, so the shift register acts on the following edge.
- Update-IR latency: `o_instruction` changes on the edge that leaves UpdIR. This is the same edge on which the shift register still holds the shifted value.
- Pause states: all strobes low. The downstream shift register holds its value.
- If reset and TMS=0 occur on the same edge, reset wins.

## Configuration
- `JTAG_TAP_IDCODE_EN`:
  - Defined: `IR_RESET_CODE` = `IR_IDCODE`, so the IDCODE data register is selected after reset/TLR.
  - Undefined: `IR_RESET_CODE` = `IR_BYPASS` (all ones, REG_W bits).
- Only the reset code changes. The FSM is identical in both builds.

## Structure
- `jtag_pa` holds:
  - `typedef enum logic [3:0] tap_state_t`, using the IEEE encoding: TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauseDR=3, Ex2DR=0, UpdDR=5, SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauseIR=B, Ex2IR=8, UpdIR=D.
  - `IR_BYPASS`, `IR_IDCODE`, and `IR_RESET_CODE`, the last selected by the macro.
- Single module, no sub-module. Next-state logic is one `always_comb` case on `state_q`.

## Test plan
- Reset pulse, then TMS=0 held: TLR after the reset edge, RTI one edge later, and RTI held. `o_instruction`=`IR_RESET_CODE`.
- From RTI, TMS sequence 1,0,0,0: states SelDR, CapDR, ShDR, ShDR. `o_stateIsCaptureDr` high for exactly one cycle, then `o_stateIsShiftDr` high.
- IR scan: from RTI, TMS 1,1,0,0 then 1,1 with `i_shiftReg`=REG_W'h05 present in UpdIR:
  - Reaches ShIR.
  - Passes Ex1IR → UpdIR with one cycle of `o_stateIsUpdateIr`.
  - `o_instruction`=5 after the UpdIR edge.
- Pause loop: ShDR, then TMS 1,0,0,0,1,0. All strobes stay low through Ex1DR/PauseDR/Ex2DR, and the FSM returns to ShDR.
- Recovery from every one of the 16 states:
  - Five TMS=1 edges reach TLR, and `o_instruction` resets.
  - Reset asserted mid-ShIR goes to TLR on the next edge.
- Build both with and without `JTAG_TAP_IDCODE_EN`: post-reset `o_instruction` equals `IR_IDCODE` or all-ones respectively.

Source files
------------

// File: rtl/jtag_tap_fsm_pkg.sv
// ---------------------------------------------------------------------------
// jtag_pa
//
// Shared definitions for the JTAG block: the shift/instruction register
// width, the 16-state TAP state type and the instruction codes.
//
// Build option:
//   JTAG_TAP_IDCODE_EN  - when defined, the instruction register resets to
//                         IDCODE so the IDCODE data register is selected
//                         after reset or Test-Logic-Reset; otherwise it
//                         resets to BYPASS (all ones).
// ---------------------------------------------------------------------------
package jtag_pa;

    // Width of the shared shift register and of the instruction register.
    localparam int REG_W = 4;

    // TAP states with the IEEE 1149.1 encoding.  All 16 codes are legal,
    // so the machine has no unreachable or illegal encodings.
    typedef enum logic [3:0] {
        TAP_EX2_DR   = 4'h0,
        TAP_EX1_DR   = 4'h1,
        TAP_SH_DR    = 4'h2,
        TAP_PAUSE_DR = 4'h3,
        TAP_SEL_IR   = 4'h4,
        TAP_UPD_DR   = 4'h5,
        TAP_CAP_DR   = 4'h6,
        TAP_SEL_DR   = 4'h7,
        TAP_EX2_IR   = 4'h8,
        TAP_EX1_IR   = 4'h9,
        TAP_SH_IR    = 4'hA,
        TAP_PAUSE_IR = 4'hB,
        TAP_RTI      = 4'hC,
        TAP_UPD_IR   = 4'hD,
        TAP_CAP_IR   = 4'hE,
        TAP_TLR      = 4'hF
    } tap_state_t;

    // BYPASS is mandated to be the all-ones instruction.
    localparam logic [REG_W-1:0] IR_BYPASS = {REG_W{1'b1}};
    localparam logic [REG_W-1:0] IR_IDCODE = 4'h1;

    // Instruction loaded on reset and on every edge spent in Test-Logic-Reset.
`ifdef JTAG_TAP_IDCODE_EN
    localparam logic [REG_W-1:0] IR_RESET_CODE = IR_IDCODE;
`else
    localparam logic [REG_W-1:0] IR_RESET_CODE = IR_BYPASS;
`endif

endpackage

// File: rtl/jtag_tap_fsm.sv
// ---------------------------------------------------------------------------
// jtag_tap_fsm
//
// IEEE 1149.1 TAP controller.  Walks the 16-state TAP machine under TMS,
// decodes the Capture/Shift/Update strobes for the shared shift register
// and holds the active instruction, which is latched from the shift register
// on the edge that leaves Update-IR.
//
// Ports:
//   i_tclk                  - TCK, the only clock (posedge)
//   i_trst_n                - synchronous reset, active HIGH despite the name
//   i_tms                   - test mode select
//   i_shiftReg              - shift-register contents (instruction source)
//   o_state                 - current TAP state
//   o_stateIsTestLogicReset - state is Test-Logic-Reset
//   o_stateIsCaptureDr/Ir   - state is Capture-DR / Capture-IR
//   o_stateIsShiftDr/Ir     - state is Shift-DR / Shift-IR
//   o_stateIsUpdateDr/Ir    - state is Update-DR / Update-IR
//   o_instruction           - active instruction
//
// Build option: JTAG_TAP_IDCODE_EN selects the reset instruction (see
// jtag_pa); the state machine itself is identical in both builds.
// ---------------------------------------------------------------------------
module jtag_tap_fsm
    import jtag_pa::*;
(
    input  logic             i_tclk,
    input  logic             i_trst_n,
    input  logic             i_tms,
    input  logic [REG_W-1:0] i_shiftReg,
    output tap_state_t       o_state,
    output logic             o_stateIsTestLogicReset,
    output logic             o_stateIsCaptureDr,
    output logic             o_stateIsCaptureIr,
    output logic             o_stateIsShiftDr,
    output logic             o_stateIsShiftIr,
    output logic             o_stateIsUpdateDr,
    output logic             o_stateIsUpdateIr,
    output logic [REG_W-1:0] o_instruction
);

    tap_state_t       state_q;
    tap_state_t       state_d;
    logic [REG_W-1:0] instr_q;
    logic [REG_W-1:0] instr_d;

    // Next TAP state: a pure function of the current state and TMS.
    // The IR column mirrors the DR column; Select-IR with TMS=1 is the
    // escape back to Test-Logic-Reset, which is why five TMS=1 edges
    // always land in TLR.
    always_comb begin
        state_d = state_q;
        case (state_q)
            TAP_TLR:      state_d = i_tms ? TAP_TLR      : TAP_RTI;
            TAP_RTI:      state_d = i_tms ? TAP_SEL_DR   : TAP_RTI;

            TAP_SEL_DR:   state_d = i_tms ? TAP_SEL_IR   : TAP_CAP_DR;
            TAP_CAP_DR:   state_d = i_tms ? TAP_EX1_DR   : TAP_SH_DR;
            TAP_SH_DR:    state_d = i_tms ? TAP_EX1_DR   : TAP_SH_DR;
            TAP_EX1_DR:   state_d = i_tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
            TAP_PAUSE_DR: state_d = i_tms ? TAP_EX2_DR   : TAP_PAUSE_DR;
            TAP_EX2_DR:   state_d = i_tms ? TAP_UPD_DR   : TAP_SH_DR;
            TAP_UPD_DR:   state_d = i_tms ? TAP_SEL_DR   : TAP_RTI;

            TAP_SEL_IR:   state_d = i_tms ? TAP_TLR      : TAP_CAP_IR;
            TAP_CAP_IR:   state_d = i_tms ? TAP_EX1_IR   : TAP_SH_IR;
            TAP_SH_IR:    state_d = i_tms ? TAP_EX1_IR   : TAP_SH_IR;
            TAP_EX1_IR:   state_d = i_tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
            TAP_PAUSE_IR: state_d = i_tms ? TAP_EX2_IR   : TAP_PAUSE_IR;
            TAP_EX2_IR:   state_d = i_tms ? TAP_UPD_IR   : TAP_SH_IR;
            TAP_UPD_IR:   state_d = i_tms ? TAP_SEL_DR   : TAP_RTI;

            default:      state_d = TAP_TLR;
        endcase
    end

    // Instruction update.  The edge that leaves Update-IR is the same edge
    // on which the shift register still holds the shifted-in value, so the
    // instruction is taken from it while state_q is Update-IR.  Sitting in
    // Test-Logic-Reset keeps reloading the reset instruction.
    always_comb begin
        instr_d = instr_q;
        if (state_q == TAP_UPD_IR) begin
            instr_d = i_shiftReg;
        end else if (state_q == TAP_TLR) begin
            instr_d = IR_RESET_CODE;
        end
    end

    // State and instruction registers.  Reset overrides TMS from any
    // state, including the middle of a shift.
    always_ff @(posedge i_tclk) begin
        if (i_trst_n) begin
            state_q <= TAP_TLR;
            instr_q <= IR_RESET_CODE;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
        end
    end

    // Strobes are plain decodes of the registered state, so they are stable
    // for the whole TCK cycle in which the shift register samples them.
    // Distinct states give mutually exclusive strobes; Pause and Exit
    // states drive none of them.
    assign o_stateIsTestLogicReset = (state_q == TAP_TLR);
    assign o_stateIsCaptureDr      = (state_q == TAP_CAP_DR);
    assign o_stateIsCaptureIr      = (state_q == TAP_CAP_IR);
    assign o_stateIsShiftDr        = (state_q == TAP_SH_DR);
    assign o_stateIsShiftIr        = (state_q == TAP_SH_IR);
    assign o_stateIsUpdateDr       = (state_q == TAP_UPD_DR);
    assign o_stateIsUpdateIr       = (state_q == TAP_UPD_IR);

    assign o_state       = state_q;
    assign o_instruction = instr_q;

endmodule

// File: tb/tb_jtag_tap_fsm.sv
// ---------------------------------------------------------------------------
// tb_jtag_tap_fsm
//
// Self-checking bench for jtag_tap_fsm: a hand-built vector table for the
// directed scans, a recovery sweep from all 16 states, and a randomized run
// checked against a table-walking reference model of the TAP graph.
// ---------------------------------------------------------------------------
module tb_jtag_tap_fsm;
    import jtag_pa::*;

    localparam logic [REG_W-1:0] ALL_ONES = {REG_W{1'b1}};
`ifdef JTAG_TAP_IDCODE_EN
    localparam logic [REG_W-1:0] EXP_RESET = IR_IDCODE;
`else
    localparam logic [REG_W-1:0] EXP_RESET = ALL_ONES;
`endif

    // Flag vector order: {tlr, capDr, capIr, shDr, shIr, updDr, updIr}
    localparam logic [6:0] F_NONE = 7'b0000000;
    localparam logic [6:0] F_TLR  = 7'b1000000;
    localparam logic [6:0] F_CDR  = 7'b0100000;
    localparam logic [6:0] F_CIR  = 7'b0010000;
    localparam logic [6:0] F_SDR  = 7'b0001000;
    localparam logic [6:0] F_SIR  = 7'b0000100;
    localparam logic [6:0] F_UDR  = 7'b0000010;
    localparam logic [6:0] F_UIR  = 7'b0000001;

    logic             clock;
    logic             trst;
    logic             tms;
    logic [REG_W-1:0] shiftReg;
    logic [3:0]       dutState;
    logic             fTlr, fCapDr, fCapIr, fShDr, fShIr, fUpdDr, fUpdIr;
    logic [REG_W-1:0] dutInstr;
    logic [6:0]       dutFlags;

    int compared   = 0;
    int mismatched = 0;

    jtag_tap_fsm dut (
        .i_tclk                  (clock),
        .i_trst_n                (trst),
        .i_tms                   (tms),
        .i_shiftReg              (shiftReg),
        .o_state                 (dutState),
        .o_stateIsTestLogicReset (fTlr),
        .o_stateIsCaptureDr      (fCapDr),
        .o_stateIsCaptureIr      (fCapIr),
        .o_stateIsShiftDr        (fShDr),
        .o_stateIsShiftIr        (fShIr),
        .o_stateIsUpdateDr       (fUpdDr),
        .o_stateIsUpdateIr       (fUpdIr),
        .o_instruction           (dutInstr)
    );

    assign dutFlags = {fTlr, fCapDr, fCapIr, fShDr, fShIr, fUpdDr, fUpdIr};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model.  States are numbered by their position in the TAP
    // graph: 0 TLR, 1 RTI, then a column of seven (Select, Capture, Shift,
    // Exit1, Pause, Exit2, Update) starting at 2 for DR and 9 for IR.
    int               mState = 0;
    logic [REG_W-1:0] mInstr = '0;
    logic [3:0]       codeOf [16];

    function automatic int modelNext(input int s, input bit t);
        int base;
        int pos;
        if (s == 0) return t ? 0 : 1;
        if (s == 1) return t ? 2 : 1;
        base = (s >= 9) ? 9 : 2;
        pos  = s - base;
        case (pos)
            0:       return t ? ((base == 2) ? 9 : 0) : base + 1;
            1, 2:    return t ? base + 3 : base + 2;
            3:       return t ? base + 6 : base + 4;
            4:       return t ? base + 5 : base + 4;
            5:       return t ? base + 6 : base + 2;
            default: return t ? 2 : 1;
        endcase
    endfunction

    function automatic logic [6:0] modelFlags(input int s);
        case (s)
            0:       return F_TLR;
            3:       return F_CDR;
            10:      return F_CIR;
            4:       return F_SDR;
            11:      return F_SIR;
            8:       return F_UDR;
            15:      return F_UIR;
            default: return F_NONE;
        endcase
    endfunction

    // Drives one TCK cycle and advances the model with the pre-edge state.
    task automatic applyStimulus(input bit rst, input bit t, input logic [REG_W-1:0] sr);
        @(negedge clock);
        trst     = rst;
        tms      = t;
        shiftReg = sr;
        @(posedge clock);
        if (rst) begin
            mState = 0;
            mInstr = EXP_RESET;
        end else begin
            if (mState == 0) mInstr = EXP_RESET;
            else if (mState == 15) mInstr = sr;
            mState = modelNext(mState, t);
        end
        #1;
    endtask

    task automatic compareField(input string name, input logic [15:0] actual,
                                input logic [15:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input string tag);
        compareField({tag, " state"}, {12'd0, dutState}, {12'd0, codeOf[mState]});
        compareField({tag, " instr"}, {{(16-REG_W){1'b0}}, dutInstr}, {{(16-REG_W){1'b0}}, mInstr});
        compareField({tag, " flags"}, {9'd0, dutFlags}, {9'd0, modelFlags(mState)});
    endtask

    typedef struct {
        bit               rst;
        bit               tms;
        logic [REG_W-1:0] sr;
        logic [3:0]       expState;
        logic [REG_W-1:0] expInstr;
        logic [6:0]       expFlags;
    } vec_t;

    localparam int NVEC = 29;
    vec_t vecs [NVEC];

    int          pathLen  [16];
    logic [7:0]  pathBits [16];

    initial begin
        codeOf = '{4'hF, 4'hC, 4'h7, 4'h6, 4'h2, 4'h1, 4'h3, 4'h0,
                   4'h5, 4'h4, 4'hE, 4'hA, 4'h9, 4'hB, 4'h8, 4'hD};

        // Directed vectors: reset, DR capture/shift, pause loop, DR update,
        // IR scan loading 5, then reset in the middle of Shift-IR.
        vecs[0]  = '{1, 0, 4'hA, 4'hF, EXP_RESET, F_TLR};
        vecs[1]  = '{0, 0, 4'hA, 4'hC, EXP_RESET, F_NONE};
        vecs[2]  = '{0, 0, 4'hA, 4'hC, EXP_RESET, F_NONE};
        vecs[3]  = '{0, 1, 4'hA, 4'h7, EXP_RESET, F_NONE};
        vecs[4]  = '{0, 0, 4'hA, 4'h6, EXP_RESET, F_CDR};
        vecs[5]  = '{0, 0, 4'hA, 4'h2, EXP_RESET, F_SDR};
        vecs[6]  = '{0, 0, 4'hA, 4'h2, EXP_RESET, F_SDR};
        vecs[7]  = '{0, 1, 4'hA, 4'h1, EXP_RESET, F_NONE};
        vecs[8]  = '{0, 0, 4'hA, 4'h3, EXP_RESET, F_NONE};
        vecs[9]  = '{0, 0, 4'hA, 4'h3, EXP_RESET, F_NONE};
        vecs[10] = '{0, 0, 4'hA, 4'h3, EXP_RESET, F_NONE};
        vecs[11] = '{0, 1, 4'hA, 4'h0, EXP_RESET, F_NONE};
        vecs[12] = '{0, 0, 4'hA, 4'h2, EXP_RESET, F_SDR};
        vecs[13] = '{0, 1, 4'hA, 4'h1, EXP_RESET, F_NONE};
        vecs[14] = '{0, 1, 4'hA, 4'h5, EXP_RESET, F_UDR};
        vecs[15] = '{0, 0, 4'hA, 4'hC, EXP_RESET, F_NONE};
        vecs[16] = '{0, 1, 4'hA, 4'h7, EXP_RESET, F_NONE};
        vecs[17] = '{0, 1, 4'hA, 4'h4, EXP_RESET, F_NONE};
        vecs[18] = '{0, 0, 4'hA, 4'hE, EXP_RESET, F_CIR};
        vecs[19] = '{0, 0, 4'hA, 4'hA, EXP_RESET, F_SIR};
        vecs[20] = '{0, 1, 4'hA, 4'h9, EXP_RESET, F_NONE};
        vecs[21] = '{0, 1, 4'h5, 4'hD, EXP_RESET, F_UIR};
        vecs[22] = '{0, 0, 4'h5, 4'hC, 4'h5,      F_NONE};
        vecs[23] = '{0, 1, 4'hA, 4'h7, 4'h5,      F_NONE};
        vecs[24] = '{0, 1, 4'hA, 4'h4, 4'h5,      F_NONE};
        vecs[25] = '{0, 0, 4'hA, 4'hE, 4'h5,      F_CIR};
        vecs[26] = '{0, 0, 4'hA, 4'hA, 4'h5,      F_SIR};
        vecs[27] = '{1, 0, 4'hA, 4'hF, EXP_RESET, F_TLR};
        vecs[28] = '{0, 1, 4'hA, 4'hF, EXP_RESET, F_TLR};

        // TMS paths from Run-Test/Idle to each model state (bit i = edge i).
        pathLen  = '{3, 0, 1, 2, 3, 3, 4, 5, 4, 2, 3, 4, 4, 5, 6, 5};
        pathBits = '{8'h07, 8'h00, 8'h01, 8'h01, 8'h01, 8'h05, 8'h05, 8'h15,
                     8'h0D, 8'h03, 8'h03, 8'h03, 8'h0B, 8'h0B, 8'h2B, 8'h1B};
    end

    // Test sequence: vector table, recovery sweep, randomized run.
    initial begin
        trst     = 1'b0;
        tms      = 1'b0;
        shiftReg = '0;
        #1;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].tms, vecs[i].sr);
            compareField($sformatf("vec%0d state", i), {12'd0, dutState}, {12'd0, vecs[i].expState});
            compareField($sformatf("vec%0d instr", i), {{(16-REG_W){1'b0}}, dutInstr},
                         {{(16-REG_W){1'b0}}, vecs[i].expInstr});
            compareField($sformatf("vec%0d flags", i), {9'd0, dutFlags}, {9'd0, vecs[i].expFlags});
            checkOutput($sformatf("vec%0d model", i));
        end

        // Recovery from every state: load instruction 6 through an IR scan,
        // walk to the target, then hold TMS=1 and expect TLR plus the reset
        // instruction on the following edge.
        for (int tgt = 0; tgt < 16; tgt++) begin
            applyStimulus(1, 0, 4'h9);
            applyStimulus(0, 0, 4'h9);
            applyStimulus(0, 1, 4'h9);
            applyStimulus(0, 1, 4'h9);
            applyStimulus(0, 0, 4'h9);
            applyStimulus(0, 0, 4'h9);
            applyStimulus(0, 1, 4'h9);
            applyStimulus(0, 1, 4'h9);
            applyStimulus(0, 0, 4'h6);
            compareField($sformatf("rec%0d loaded", tgt), {{(16-REG_W){1'b0}}, dutInstr}, 16'h0006);
            for (int k = 0; k < pathLen[tgt]; k++) begin
                applyStimulus(0, pathBits[tgt][k], 4'h9);
            end
            compareField($sformatf("rec%0d reached", tgt), {12'd0, dutState}, {12'd0, codeOf[tgt]});
            for (int k = 0; k < 5; k++) begin
                applyStimulus(0, 1, 4'h9);
                checkOutput($sformatf("rec%0d tms1_%0d", tgt, k));
            end
            compareField($sformatf("rec%0d tlr", tgt), {12'd0, dutState}, 16'h000F);
            applyStimulus(0, 1, 4'h9);
            compareField($sformatf("rec%0d instr", tgt), {{(16-REG_W){1'b0}}, dutInstr},
                         {{(16-REG_W){1'b0}}, EXP_RESET});
        end

        // Randomized TMS/shift-register traffic with occasional resets.
        applyStimulus(1, 0, '0);
        checkOutput("rand reset");
        for (int n = 0; n < 600; n++) begin
            applyStimulus(($urandom_range(0, 29) == 0), 1'($urandom), REG_W'($urandom));
            checkOutput($sformatf("rand%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
